// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline register: per-slice state encoding
// and the occupancy-counter width helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } slice_state_e;

    function automatic int cnt_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// Stream bus of pipe_reg: upstream valid/ready/data, downstream valid/ready/data,
// occupancy. flush_i exists only when PIPE_REG_FLUSH_EN is defined.
interface pipe_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 2
);
    localparam int CNT_W = cnt_width(STAGES);

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic [CNT_W-1:0]      count_o;
`ifdef PIPE_REG_FLUSH_EN
    logic                  flush_i;
`endif

    modport master (
`ifdef PIPE_REG_FLUSH_EN
        output flush_i,
`endif
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, count_o
    );

    modport slave (
`ifdef PIPE_REG_FLUSH_EN
        input  flush_i,
`endif
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, count_o
    );

endinterface

// File: rtl/pipe_slice.sv
// One elastic skid slice: main and skid registers, EMPTY/BUSY/FULL state and a
// registered ready. The flush input is compiled in only with PIPE_REG_FLUSH_EN.
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef PIPE_REG_FLUSH_EN
    input  logic                  flush_i,
`endif
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    input  logic [DATA_WIDTH-1:0] up_data_i,
    output logic                  dn_valid_o,
    input  logic                  dn_ready_i,
    output logic [DATA_WIDTH-1:0] dn_data_o
);
    slice_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  ready_q;
    logic                  in_fire, out_fire, flush;

    assign in_fire  = up_valid_i && ready_q;
    assign out_fire = (state_q != EMPTY) && dn_ready_i;
`ifdef PIPE_REG_FLUSH_EN
    assign flush    = flush_i;
`else
    assign flush    = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d signal gets its hold value first so no path can infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_d = BUSY;
                    main_d  = up_data_i;
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = up_data_i;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = up_data_i;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (out_fire) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments only; payload registers are
    // reset as well so the output word reads zero straight out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != FULL);
        end
    end

    assign up_ready_o = ready_q;
    assign dn_valid_o = (state_q != EMPTY);
    assign dn_data_o  = main_q;

endmodule

// File: rtl/pipe_reg.sv
// Elastic pipeline register: STAGES skid slices in series plus an occupancy counter.
// Optional synchronous flush is enabled by defining PIPE_REG_FLUSH_EN.
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    pipe_reg_if.slave  bus
);
    localparam int CNT_W = cnt_width(STAGES);

    logic                  valid [STAGES+1];
    logic                  ready [STAGES+1];
    logic [DATA_WIDTH-1:0] data  [STAGES+1];
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  in_fire, out_fire, flush;

    assign valid[0]      = bus.in_valid_i;
    assign data[0]       = bus.in_data_i;
    assign ready[STAGES] = bus.out_ready_i;
`ifdef PIPE_REG_FLUSH_EN
    assign flush         = bus.flush_i;
`else
    assign flush         = 1'b0;
`endif

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        pipe_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
`ifdef PIPE_REG_FLUSH_EN
            .flush_i    (bus.flush_i),
`endif
            .up_valid_i (valid[i]),
            .up_ready_o (ready[i]),
            .up_data_i  (data[i]),
            .dn_valid_o (valid[i+1]),
            .dn_ready_i (ready[i+1]),
            .dn_data_o  (data[i+1])
        );
    end

    // Only the pipe boundaries change occupancy; slice-to-slice moves are neutral.
    assign in_fire  = bus.in_valid_i && ready[0];
    assign out_fire = valid[STAGES] && bus.out_ready_i;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.in_ready_o  = ready[0];
    assign bus.out_valid_o = valid[STAGES];
    assign bus.out_data_o  = data[STAGES];
    assign bus.count_o     = count_q;

endmodule

// File: tb/tb_pipe_reg.sv
// Directed + random bench for pipe_reg (DATA_WIDTH=8, STAGES=2) with a queue scoreboard.
// The flush scenario is compiled in when PIPE_REG_FLUSH_EN is defined.
module tb_pipe_reg;
    localparam int DW = 8;
    localparam int ST = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_reg_if #(.DATA_WIDTH(DW), .STAGES(ST)) bus ();

    pipe_reg #(.DATA_WIDTH(DW), .STAGES(ST)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_in  = 0;
    int n_out = 0;
    int first_in_cyc, first_out_cyc, last_out_cyc;
    bit last_in_fire, last_out_fire;
    logic [DW-1:0] last_out_data;
    logic [DW-1:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: decide handshakes from the settled pre-edge values, update the
    // scoreboard, advance to the next falling edge, then check occupancy.
    task automatic cycle();
        bit in_fire, out_fire, flush;
        logic [DW-1:0] exp_w;
`ifdef PIPE_REG_FLUSH_EN
        flush = bus.flush_i;
`else
        flush = 1'b0;
`endif
        in_fire  = !rst && bus.in_valid_i && bus.in_ready_o;
        out_fire = !rst && bus.out_valid_o && bus.out_ready_i;
        if (out_fire) begin
            check("sb_has_word", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_w = sb.pop_front();
                check("out_data", 32'(bus.out_data_o), 32'(exp_w));
            end
            last_out_data = bus.out_data_o;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            n_out++;
        end
        if (in_fire) begin
            if (!flush) sb.push_back(bus.in_data_i);
            if (first_in_cyc < 0) first_in_cyc = cyc;
            n_in++;
        end
        if (rst || flush) sb.delete();
        last_in_fire  = in_fire;
        last_out_fire = out_fire;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("count_vs_sb", 32'(bus.count_o), 32'(sb.size()));
    endtask

    task automatic push_words(input int n, input logic [DW-1:0] first, input int budget);
        int acc = 0;
        logic [DW-1:0] w = first;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = w;
        for (int i = 0; i < budget && acc < n; i++) begin
            cycle();
            if (last_in_fire) begin
                acc++;
                w++;
                bus.in_data_i = w;
            end
        end
        bus.in_valid_i = 1'b0;
        check("push_accepted", 32'(acc), 32'(n));
    endtask

    task automatic drain(input int budget);
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < budget && sb.size() > 0; i++) cycle();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic expect_first_out(input string tag, input logic [DW-1:0] w);
        int n0 = n_out;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 10 && n_out == n0; i++) cycle();
        check({tag, "_seen"}, 32'(n_out - n0), 32'd1);
        check({tag, "_data"}, 32'(last_out_data), 32'(w));
    endtask

    initial begin
        int c0, acc, n0;
        bit pend;
        logic [DW-1:0] w;

        // Reset with input offered.
        rst             = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 8'hAA;
        bus.out_ready_i = 1'b0;
`ifdef PIPE_REG_FLUSH_EN
        bus.flush_i     = 1'b0;
`endif
        first_in_cyc  = -1;
        first_out_cyc = -1;
        last_out_cyc  = -1;
        repeat (3) begin
            cycle();
            check("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
            check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
            check("rst_out_data", 32'(bus.out_data_o), 32'd0);
        end
        rst = 1'b0;
        cycle();
        check("rel_in_ready", 32'(bus.in_ready_o), 32'd1);
        check("rel_count", 32'(bus.count_o), 32'd0);
        check("rel_out_valid", 32'(bus.out_valid_o), 32'd0);
        bus.in_valid_i = 1'b0;

        // Back-to-back streaming.
        bus.out_ready_i = 1'b1;
        first_in_cyc  = -1;
        first_out_cyc = -1;
        c0 = cyc;
        bus.in_valid_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.in_data_i = 8'(i);
            check("stream_in_ready", 32'(bus.in_ready_o), 32'd1);
            cycle();
            if (i == 9) check("stream_count", 32'(bus.count_o), 32'd2);
        end
        bus.in_valid_i = 1'b0;
        check("stream_in_cycles", 32'(cyc - c0), 32'd16);
        drain(10);
        check("stream_latency", 32'(first_out_cyc - first_in_cyc), 32'(ST));
        check("stream_no_bubble", 32'(last_out_cyc - first_out_cyc), 32'd15);

        // Backpressure: stalled output fills the pipe to 2*STAGES words.
        bus.out_ready_i = 1'b0;
        acc = 0;
        w   = 8'h20;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = w;
        repeat (8) begin
            cycle();
            if (last_in_fire) begin
                acc++;
                w++;
                bus.in_data_i = w;
            end
        end
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
        check("bp_count", 32'(bus.count_o), 32'd4);
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 40 && acc < 12; i++) begin
            cycle();
            if (last_in_fire) begin
                acc++;
                w++;
                bus.in_data_i = w;
            end
        end
        bus.in_valid_i = 1'b0;
        check("bp_resume", 32'(acc), 32'd12);
        drain(20);

        // Random stalls on both sides.
        n0 = n_in;
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < 8000 && (n_in - n0) < 1000; i++) begin
            pend = bus.in_valid_i && !last_in_fire;
            if (i == 0) pend = 1'b0;
            if (!pend) begin
                bus.in_valid_i = 1'($urandom_range(0, 1));
                bus.in_data_i  = 8'($urandom_range(0, 255));
            end
            bus.out_ready_i = 1'($urandom_range(0, 1));
            cycle();
        end
        bus.in_valid_i = 1'b0;
        check("rand_words", 32'(n_in - n0), 32'd1000);
        drain(20);

        // Reset while three words are held.
        bus.out_ready_i = 1'b0;
        push_words(3, 8'h40, 10);
        check("mid_count", 32'(bus.count_o), 32'd3);
        rst            = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'hEE;
        cycle();
        rst            = 1'b0;
        bus.in_valid_i = 1'b0;
        cycle();
        check("mid_rst_count", 32'(bus.count_o), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        bus.out_ready_i = 1'b1;
        push_words(1, 8'h5A, 5);
        expect_first_out("mid_rst_first", 8'h5A);
        drain(10);

`ifdef PIPE_REG_FLUSH_EN
        // Flush with the pipe full and a word offered.
        bus.out_ready_i = 1'b0;
        push_words(4, 8'h60, 10);
        bus.flush_i    = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'h77;
        cycle();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        check("flush_count", 32'(bus.count_o), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready_o), 32'd1);
        check("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
        bus.out_ready_i = 1'b1;
        push_words(1, 8'h33, 5);
        expect_first_out("flush_first", 8'h33);
        drain(10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised elastic pipeline register: a chain of `STAGES` valid/ready register slices carrying `DATA_WIDTH`-bit words at full throughput with registered backpressure. It replaces the plain data flip-flop wherever a registered path also has to stall. It sits between any two streaming blocks to break timing on data, valid and ready simultaneously.

## Interface
- `DATA_WIDTH`, 8, payload width in bits (≥1)
- `STAGES`, 2, number of register slices (≥1)
- `CNT_W`, `$clog2(2*STAGES+1)`, occupancy counter width (derived, not overridden)

- `clk_i`  in  1  clock; all logic on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `in_valid_i`  in  1  upstream word valid
- `in_ready_o`  out  1  pipe accepts a word this cycle (registered)
- `in_data_i`  in  DATA_WIDTH  upstream payload
- `out_valid_o`  out  1  word available at output (registered)
- `out_ready_i`  in  1  downstream accepts
- `out_data_o`  out  DATA_WIDTH  output payload (registered)
- `count_o`  out  CNT_W  words held in pipe (registered)
- `flush_i`  in  1  drop all contents (present only with `PIPE_REG_FLUSH_EN`)

## Operation
- Transfer occurs on a port when valid and ready are both 1 at a rising edge. Valid must not depend on ready. Data is held stable while valid && !ready.
- Each slice has a main register and a skid register. States:
  - EMPTY: main empty.
  - BUSY: main full, skid empty.
  - FULL: both full.
- Slice outputs:
  - slice valid = state != EMPTY; slice data = main.
  - slice ready = registered (state_next != FULL).
- Transitions (in = input transfer, out = output transfer):
  - EMPTY + in → BUSY, main ← in.
  - BUSY + in + out → BUSY, main ← in.
  - BUSY + in only → FULL, skid ← in.
  - BUSY + out only → EMPTY.
  - FULL + out → BUSY, main ← skid. FULL never accepts input.
- Order is strictly preserved. No word is duplicated or dropped except by reset or flush.
- Total capacity 2·STAGES words.
- `count_o` = number of full registers across all slices. Simultaneous in and out transfers leave it unchanged.
- Reset values:
  - all state EMPTY; all main and skid data 0.
  - `out_valid_o`=0, `out_data_o`=0, `count_o`=0.
  - `in_ready_o`=0 while `rst_i`=1; it rises to 1 in the first cycle after reset deasserts.
- Reset mid-stream discards all words. Input offered during a reset cycle is not accepted.

## Timing
- Latency: a word accepted at edge k into an empty pipe appears on `out_valid_o`/`out_data_o` after edge k+STAGES-1, so it is visible for the first time in cycle k+STAGES.
- Throughput: 1 word/cycle sustained with `out_ready_i`=1.
- `out_ready_i` falling: `in_ready_o` falls no earlier than the cycle after. The skid registers absorb words in flight.
- `out_ready_i` rising after the pipe is full: the output drains 1 word/cycle. `in_ready_o` returns 1 the cycle after the first slice leaves FULL.
- No combinational path from any input to any output.

## Configuration
- `PIPE_REG_FLUSH_EN` defined:
  - `flush_i` port exists.
  - `flush_i`=1 at an edge sets all slices EMPTY and `count_o` to 0 after that edge. Data registers keep their values.
  - An input transfer in the same cycle is discarded; the upstream treats it as consumed.
  - An output transfer in that cycle completes normally.
  - `in_ready_o`=1 the following cycle.
  - Reset has priority over flush.
- Undefined: no `flush_i` port and no flush logic. Contents are cleared only by `rst_i`.

## Structure
- Shared package `pipe_pkg`: slice state enum typedef (`EMPTY`, `BUSY`, `FULL`) and the count-width function.
- Sub-module `pipe_slice`: one skid slice holding the state machine, main and skid registers, and registered ready. `pipe_reg` instantiates `STAGES` of them in a generate loop and maintains `count_o` as a single up/down counter.

## Test plan
- Reset: drive `rst_i`=1 for 3 cycles with `in_valid_i`=1, data 0xAA → `out_valid_o`=0, `count_o`=0, `in_ready_o`=0 throughout; `in_ready_o`=1 in the first cycle after release.
- Streaming, STAGES=2: send 0x01..0x10 back to back with `out_ready_i`=1 → output is 0x01..0x10 in order, first valid 2 cycles after the first accept, no bubbles, `count_o` steady at 2.
- Backpressure: hold `out_ready_i`=0 while streaming → exactly 4 words accepted, `in_ready_o`=0, `count_o`=4; release → 4 words drain in order, then streaming resumes with no loss.
- Random stall: random `in_valid_i` and `out_ready_i` at 50 %, 1000 words with a scoreboard → zero mismatches; `count_o` always equals scoreboard depth.
- Reset mid-stream with 3 words held → after reset `count_o`=0, `out_valid_o`=0, and the next word sent (0x5A) is the first one out.
- Flush (`PIPE_REG_FLUSH_EN`): with 4 words held, pulse `flush_i` together with input 0x77 → `count_o`=0 the next cycle, 0x77 never appears at the output, and the next word 0x33 passes normally.
